// File: rtl/dm_responder.sv
// Data-memory responder for the core's m_data_* port.
// Clears the whole array after reset, then serves combinational reads and
// byte-enabled stores, and emits a one-cycle trace record per committed store.
module dm_responder #(
  parameter int WORDS      = 4096,
  parameter int ADDR_WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        ready,
  output logic        log_valid,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic [31:0] log_pc,
  output logic        err_range
);

  typedef enum logic {CLEAR, SERVE} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic [31:0]           mem [WORDS];

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  in_range;
  logic                  serving;
  logic                  store_req;
  logic                  store_we;
  logic                  clear_we;
  logic [31:0]           cur_word;
  logic [31:0]           merged;
  logic                  unused_addr_bits;

  // Overwrite only the enabled byte lanes of the old word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  // Byte offset bits never select anything; they only reach the trace as zeros.
  assign unused_addr_bits = ^m_data_addr[1:0];

  assign word_idx  = m_data_addr[ADDR_WIDTH+1:2];
  assign in_range  = (m_data_addr[31:ADDR_WIDTH+2] == '0);
  assign serving   = (state == SERVE);
  assign store_req = serving && (m_data_byteen != 4'b0000);
  assign store_we  = store_req && in_range;
  assign clear_we  = (state == CLEAR);
  assign cur_word  = mem[word_idx];
  assign merged    = merge_bytes(cur_word, m_data_wdata, m_data_byteen);

  assign ready        = serving;
  assign m_data_rdata = (serving && in_range) ? cur_word : 32'h0;

  // State register and clear-index counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) clr_idx <= clr_idx + 1'b1;
    end
  end

  // Leave CLEAR on the edge that writes the last word.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_idx == {ADDR_WIDTH{1'b1}}) state_next = SERVE;
      SERVE:   state_next = SERVE;
      default: state_next = CLEAR;
    endcase
  end

  // Array write port: zero-fill while clearing, merged store while serving.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clr_idx] <= 32'h0;
    end else if (store_we) begin
      mem[word_idx] <= merged;
    end
  end

  // Store trace record; data fields hold between pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      log_valid <= 1'b0;
      log_addr  <= 32'h0;
      log_data  <= 32'h0;
      log_pc    <= 32'h0;
    end else begin
      log_valid <= store_we;
      if (store_we) begin
        log_addr <= {m_data_addr[31:2], 2'b00};
        log_data <= merged;
        log_pc   <= m_inst_addr;
      end
    end
  end

  // Sticky flag for stores aimed outside the array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_range <= 1'b0;
    end else if (store_req && !in_range) begin
      err_range <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: vector table plus trace scoreboard.
module tb_dm_responder;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        ready;
  logic        log_valid;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic [31:0] log_pc;
  logic        err_range;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
    logic [31:0] exp_rd;
    logic        exp_log;
    logic [31:0] exp_word;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] p;
  } rec_t;

  vec_t vecs[12];
  rec_t sb[$];

  dm_responder dut (
    .clk          (clk),
    .reset        (reset),
    .m_data_addr  (m_data_addr),
    .m_data_wdata (m_data_wdata),
    .m_data_byteen(m_data_byteen),
    .m_inst_addr  (m_inst_addr),
    .m_data_rdata (m_data_rdata),
    .ready        (ready),
    .log_valid    (log_valid),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_pc       (log_pc),
    .err_range    (err_range)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Count edges after release until ready; 0 if it never comes in budget.
  task automatic wait_ready(output int edges);
    edges = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk);
      #1;
      if (ready === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  // One access cycle: check the pre-edge read, then the trace after the edge.
  task automatic step(input vec_t v, input string name);
    rec_t r;
    m_data_addr   = v.addr;
    m_data_wdata  = v.wdata;
    m_data_byteen = v.be;
    m_inst_addr   = v.pc;
    #1;
    chk({name, "_rdata"}, m_data_rdata, v.exp_rd);
    if (v.exp_log) begin
      r.a = {v.addr[31:2], 2'b00};
      r.d = v.exp_word;
      r.p = v.pc;
      sb.push_back(r);
    end
    @(posedge clk);
    #1;
    chk({name, "_log_valid"}, {31'b0, log_valid}, {31'b0, v.exp_log});
    if (log_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_unexpected_log actual=%h required=none", name, log_addr);
      end else begin
        r = sb.pop_front();
        chk({name, "_log_addr"}, log_addr, r.a);
        chk({name, "_log_data"}, log_data, r.d);
        chk({name, "_log_pc"}, log_pc, r.p);
      end
    end
    m_data_byteen = 4'b0000;
  endtask

  initial begin
    int   edges;
    logic saw_log;
    vec_t v;
    checks   = 0;
    failures = 0;

    vecs[0]  = '{32'h0000_0100, 32'h1234_5678, 4'b1111, 32'h3000, 32'h0000_0000, 1'b1, 32'h1234_5678};
    vecs[1]  = '{32'h0000_0101, 32'h0000_AB00, 4'b0010, 32'h3004, 32'h1234_5678, 1'b1, 32'h1234_AB78};
    vecs[2]  = '{32'h0000_0102, 32'hBEEF_0000, 4'b1100, 32'h3008, 32'h1234_AB78, 1'b1, 32'hBEEF_AB78};
    vecs[3]  = '{32'h0000_0200, 32'h1111_1111, 4'b1111, 32'h300C, 32'h0000_0000, 1'b1, 32'h1111_1111};
    vecs[4]  = '{32'h0000_0204, 32'h2222_2222, 4'b0001, 32'h3010, 32'h0000_0000, 1'b1, 32'h0000_0022};
    vecs[5]  = '{32'h0000_0204, 32'h0000_0000, 4'b0000, 32'h3014, 32'h0000_0022, 1'b0, 32'h0};
    vecs[6]  = '{32'h0000_0100, 32'h0000_0000, 4'b0000, 32'h0000, 32'hBEEF_AB78, 1'b0, 32'h0};
    vecs[7]  = '{32'h0000_4000, 32'hFFFF_FFFF, 4'b1111, 32'h3018, 32'h0000_0000, 1'b0, 32'h0};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 4'b0000, 32'h0000, 32'h0000_0000, 1'b0, 32'h0};
    vecs[9]  = '{32'h0000_0008, 32'hCAFE_BABE, 4'b0101, 32'h301C, 32'h0000_0000, 1'b1, 32'h00FE_00BE};
    vecs[10] = '{32'h0000_0008, 32'h0000_0000, 4'b0000, 32'h0000, 32'h00FE_00BE, 1'b0, 32'h0};
    vecs[11] = '{32'h0000_4003, 32'h0000_0000, 4'b0000, 32'h0000, 32'h0000_0000, 1'b0, 32'h0};

    reset         = 1'b0;
    m_data_addr   = 32'h10;
    m_data_wdata  = 32'h0;
    m_data_byteen = 4'b0000;
    m_inst_addr   = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_log_valid", {31'b0, log_valid}, 32'h0);
    chk("rst_log_addr", log_addr, 32'h0);
    chk("rst_err_range", {31'b0, err_range}, 32'h0);

    // Release reset; stores during CLEAR must be ignored.
    reset   = 1'b1;
    saw_log = 1'b0;
    edges   = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk);
      #1;
      if (log_valid === 1'b1 || err_range === 1'b1) saw_log = 1'b1;
      if (k == 2) begin
        chk("clear_rdata_0x10", m_data_rdata, 32'h0);
        m_data_addr   = 32'h20;
        m_data_wdata  = 32'hFFFF_FFFF;
        m_data_byteen = 4'b1111;
      end
      if (ready === 1'b1) begin
        edges = k;
        break;
      end
    end
    m_data_byteen = 4'b0000;
    chk("ready_edge", edges, 32'd4096);
    chk("clear_no_log", {31'b0, saw_log}, 32'h0);
    if (edges == 0) begin
      $display("FAIL ready_timeout actual=0 required=4096");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "ready never asserted");
    end
    m_data_addr = 32'h20;
    #1;
    chk("clear_word_0x20", m_data_rdata, 32'h0);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end
    chk("err_sticky", {31'b0, err_range}, 32'h1);
    chk("sb_empty", sb.size(), 32'd0);

    // Reset while a trace pulse is high and err_range is set.
    v = '{32'h0000_0100, 32'h5555_5555, 4'b1111, 32'h4000, 32'hBEEF_AB78, 1'b1, 32'h5555_5555};
    step(v, "pre_reset");
    reset = 1'b0;
    #1;
    chk("async_ready", {31'b0, ready}, 32'h0);
    chk("async_log_valid", {31'b0, log_valid}, 32'h0);
    chk("async_err_range", {31'b0, err_range}, 32'h0);
    chk("async_log_data", log_data, 32'h0);
    @(posedge clk);
    #1;
    reset       = 1'b1;
    m_data_addr = 32'h100;
    wait_ready(edges);
    chk("re_ready_edge", edges, 32'd4096);
    #1;
    chk("re_clear_0x100", m_data_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
Data-memory responder for the pipelined MIPS core's data port. It is the memory end of the m_data_* interface. It serves combinational reads to the core's MA stage and commits byte-enabled stores on the clock edge. After reset it zero-clears the whole array with a sequential clear FSM, and it emits a registered one-cycle store-trace record for every committed write.

Parameters:
WORDS, 4096, number of 32-bit words; must be a power of 2.
ADDR_WIDTH, 12, log2(WORDS); word index = m_data_addr[ADDR_WIDTH+1:2].

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = in reset).
m_data_addr  input  32  byte address from the core's MA stage.
m_data_wdata  input  32  store data, already lane-aligned by the core.
m_data_byteen  input  4  byte-lane write enables; 4'b0000 = no store.
m_inst_addr  input  32  PC of the MA-stage instruction, used only for the trace.
m_data_rdata  output  32  read word at m_data_addr, combinational.
ready  output  1  1 = clear done, memory serving.
log_valid  output  1  one-cycle pulse per committed store.
log_addr  output  32  word-aligned store address: {addr[31:2],2'b00}.
log_data  output  32  full word after the merge.
log_pc  output  32  m_inst_addr of the store.
err_range  output  1  sticky out-of-range store flag.

Behaviour:
- Reset (reset=0, async): state to CLEAR; clr_idx=0; ready=0; log_valid=0; log_addr/log_data/log_pc=0; err_range=0. The array has no async reset and is cleared by the FSM.
- States: CLEAR, SERVE.
- CLEAR, after reset deasserts:
  - Rising edge k (k=1..WORDS) writes 0 to word k-1.
  - On edge WORDS, the state moves to SERVE and ready=1.
  - ready first reads 1 after exactly WORDS edges.
  - In CLEAR, m_data_byteen is ignored (no write, no log, no err) and m_data_rdata=0.
- Reset asserted mid-CLEAR or mid-SERVE: immediate return to reset values. A later release restarts the clear from word 0.
- In-range address: m_data_addr[31:ADDR_WIDTH+2]==0. Address bits [1:0] are ignored for indexing.
- SERVE read:
  - m_data_rdata = mem[index] combinationally in the same cycle.
  - Out-of-range address gives 0.
  - A same-cycle store is not visible; the pre-edge value is returned.
  - The stored value is visible from the cycle after the edge (read-after-write, next cycle).
- SERVE write:
  - Condition: rising edge with byteen!=0 and an in-range address.
  - For each i where byteen[i]=1, byte i of the word is set to wdata[8i+7:8i]; other bytes are kept.
  - Non-contiguous enables are legal.
- Trace:
  - The edge that commits a store registers log_valid=1, log_addr, log_data (merged word), log_pc=m_inst_addr.
  - Any edge without a committed store sets log_valid=0 (log_* data fields hold their last values).
  - Back-to-back stores give back-to-back pulses, each with its own record.
- Out-of-range store (SERVE, byteen!=0): no array change, no log pulse; err_range is set to 1 and stays 1 until reset.
- No stall/busy toward the core: in SERVE every access completes in one cycle.

Test Plan:
1. Release reset, sample ready each edge -> ready=0 through edge 4095, ready=1 after edge 4096; rdata at 0x10 = 0x00000000; byteen=1111 at 0x20 during CLEAR -> no log_valid, word 0x20 reads 0 in SERVE.
2. SERVE: addr 0x100, wdata 0x12345678, byteen 1111, inst 0x3000 -> on the next cycle log_valid=1, log_addr=0x100, log_data=0x12345678, log_pc=0x3000; rdata at 0x100 = 0x12345678; same-cycle rdata = 0.
3. After 2: addr 0x101, wdata 0x0000AB00, byteen 0010 -> word 0x1234AB78, log_data=0x1234AB78, log_addr=0x100. Then addr 0x102, wdata 0xBEEF0000, byteen 1100 -> word 0xBEEFAB78.
4. Back-to-back: 0x200/0x11111111/1111 then 0x204/0x22222222/0001 -> two consecutive log_valid pulses; 0x204 reads 0x00000022; third cycle with byteen 0000 -> log_valid=0.
5. Out of range: addr 0x00004000, byteen 1111 -> no log pulse, err_range=1 and stays 1 across later valid stores; rdata at 0x4000 = 0; word 0x0 unchanged.
6. Assert reset during SERVE (after 2) -> ready, log_valid, err_range all 0 immediately; after release plus 4096 edges, 0x100 reads 0x00000000.
